seg_scan_mux: RTL and testbench

Time-multiplexed scan driver for a multi-digit common-anode seven-segment display. It holds one 4-bit value per digit and steps through the digits at a programmable rate. Each digit slot presents that digit's nibble to the downstream `sevenseg` decoder and drives the matching active-low digit enable. A guard interval at each digit change prevents ghosting, display updates are double-buffered so a frame never tears, and optional leading-zero blanking is supported.

---
 rtl/seg_pkg.sv | 16 +
 rtl/scan_prescaler.sv | 36 +++
 rtl/seg_scan_mux.sv | 144 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan driver
package seg_pkg;

  // Scan slot phase: enables all off (GUARD) or one digit driven (DRIVE).
  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } seg_scan_state_t;

  // Width of one digit value presented to the decoder.
  localparam int SEG_DIGIT_W = 4;

  // Default number of digits on the display.
  localparam int SEG_NDIG = 4;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - modulo-DIV slot counter with end-of-slot flag
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [$clog2(DIV)-1:0] count,
  output logic                   slot_end
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign slot_end = (count_q == CW'(DIV - 1));
  assign count    = count_q;

  // Next count: wrap to zero after the last cycle of the slot.
  always_comb begin
    count_d = count_q + CW'(1);
    if (slot_end) begin
      count_d = '0;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed scan driver with guard, double buffer and zero blanking
module seg_scan_mux
  import seg_pkg::seg_scan_state_t, seg_pkg::SEG_DIGIT_W, seg_pkg::SEG_NDIG;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16,
  parameter int NDIG  = SEG_NDIG
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [SEG_DIGIT_W*NDIG-1:0]   digits_in,
  input  logic                          blank_lz,
  output logic [SEG_DIGIT_W-1:0]        nibble_out,
  output logic [NDIG-1:0]               digit_en_n,
  output logic                          frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  typedef logic [NDIG-1:0][SEG_DIGIT_W-1:0] digit_arr_t;

  logic [CW-1:0]          count;
  logic                   slot_end;

  seg_scan_state_t        state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  digit_arr_t             disp_q, disp_d;
  digit_arr_t             shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [SEG_DIGIT_W-1:0] nibble_q, nibble_d;
  logic [NDIG-1:0]        en_n_q, en_n_d;
  logic                   tick_q, tick_d;

  logic                   enter_drive;
  logic                   leave_drive;
  logic                   wrap;
  logic                   upper_zero;
  logic                   blank;

  scan_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .slot_end (slot_end)
  );

  // Slot FSM, display buffering, blanking decision and next registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    nibble_d    = nibble_q;
    en_n_d      = en_n_q;
    tick_d      = 1'b0;
    upper_zero  = 1'b1;
    blank       = 1'b0;

    enter_drive = (state_q == seg_pkg::GUARD) && (count == CW'(GUARD - 1));
    leave_drive = (state_q == seg_pkg::DRIVE) && slot_end;
    wrap        = leave_drive && (idx_q == IW'(NDIG - 1));

    if (enter_drive) begin
      state_d = seg_pkg::DRIVE;
    end
    if (leave_drive) begin
      state_d = seg_pkg::GUARD;
      idx_d   = wrap ? '0 : idx_q + IW'(1);
    end

    // A load landing on the wrap edge or in the tick cycle goes straight to
    // the display so it is shown from digit 0 of the frame just starting.
    if (load) begin
      shadow_d = digit_arr_t'(digits_in);
      if (wrap || tick_q) begin
        disp_d    = digit_arr_t'(digits_in);
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    tick_d = wrap;

    // The tick-cycle reload picks up a load arriving together with frame_tick.
    if (leave_drive || tick_q) begin
      nibble_d = disp_d[idx_d];
    end

    // Digit i blanks only if it and every more significant digit are zero.
    for (int i = NDIG - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp_d[i] == '0);
      if (idx_q == IW'(i)) begin
        blank = upper_zero;
      end
    end
    blank = blank & blank_lz;

    if (enter_drive) begin
      en_n_d = '1;
      if (!blank) begin
        en_n_d[idx_q] = 1'b0;
      end
    end else if (leave_drive) begin
      en_n_d = '1;
    end
  end

  // State and output registers; reset drops the enables and any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= seg_pkg::GUARD;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      nibble_q  <= '0;
      en_n_q    <= '1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      nibble_q  <= nibble_d;
      en_n_q    <= en_n_d;
      tick_q    <= tick_d;
    end
  end

  assign nibble_out = nibble_q;
  assign digit_en_n = en_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for the seven-segment scan driver
module tb_seg_scan_mux;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int NDIG  = 4;
  localparam int F     = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en_n;
  logic        frame_tick;

  seg_scan_mux #(
    .DIV   (DIV),
    .GUARD (GUARD),
    .NDIG  (NDIG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .nibble_out (nibble_out),
    .digit_en_n (digit_en_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the frame drives everything.
  int         m_t;
  logic [3:0] m_disp[NDIG];
  logic [3:0] m_shadow[NDIG];
  bit         m_pend;
  logic [3:0] m_nib;
  bit         m_blank;
  logic [3:0] e_en;
  logic [3:0] e_nib;
  logic       e_tick;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] din;
    logic [3:0]  en;
    logic [3:0]  nib;
    logic        tick;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < NDIG; i++) begin
      m_disp[i]   = '0;
      m_shadow[i] = '0;
    end
    m_pend  = 0;
    m_nib   = '0;
    m_blank = 0;
    e_en    = 4'hF;
    e_nib   = '0;
    e_tick  = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [15:0] din, input logic blz);
    int  p, np, slot, pos;
    bit  tick_cyc, last_cyc, allz;
    p        = m_t % F;
    tick_cyc = (p == 0) && (m_t > 0);
    last_cyc = (p == F - 1);
    if (ld) begin
      for (int i = 0; i < NDIG; i++) begin
        if (tick_cyc || last_cyc) m_disp[i] = din[i*4 +: 4];
        else                      m_shadow[i] = din[i*4 +: 4];
      end
      m_pend = !(tick_cyc || last_cyc);
    end else if (last_cyc && m_pend) begin
      for (int i = 0; i < NDIG; i++) m_disp[i] = m_shadow[i];
      m_pend = 0;
    end
    m_t++;
    np   = m_t % F;
    slot = np / DIV;
    pos  = np % DIV;
    if (pos == 0 || tick_cyc) m_nib = m_disp[slot];
    if (pos == GUARD) begin
      allz = 1;
      for (int j = slot; j < NDIG; j++) if (m_disp[j] != 0) allz = 0;
      m_blank = blz && (slot >= 1) && allz;
    end
    e_tick = (np == 0);
    e_en   = (pos < GUARD || m_blank) ? 4'hF : ~(4'b0001 << slot);
    e_nib  = m_nib;
  endtask

  // One clock cycle: compare against the model, apply inputs, advance.
  task automatic cyc(input logic ld, input logic [15:0] din, input logic blz);
    chk("model_en", {28'd0, digit_en_n}, {28'd0, e_en});
    chk("model_nib", {28'd0, nibble_out}, {28'd0, e_nib});
    chk("model_tick", {31'd0, frame_tick}, {31'd0, e_tick});
    load      = ld;
    digits_in = din;
    blank_lz  = blz;
    @(posedge clk);
    model_step(ld, din, blz);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", {28'd0, digit_en_n}, 32'hF);
    chk("rst_nib", {28'd0, nibble_out}, 32'h0);
    chk("rst_tick", {31'd0, frame_tick}, 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    logic       ld;
    logic [15:0] din;
    logic       blz;
    logic [3:0] exp_nib_arr[NDIG];
    int         seen1;
    int         p, slot, pos;
    logic [3:0] want_en;

    vt.push_back('{0,  1'b0, 16'h0000, 4'hF, 4'h0, 1'b0});
    vt.push_back('{1,  1'b0, 16'h0000, 4'hF, 4'h0, 1'b0});
    vt.push_back('{2,  1'b0, 16'h0000, 4'hE, 4'h0, 1'b0});
    vt.push_back('{5,  1'b1, 16'h1234, 4'hE, 4'h0, 1'b0});
    vt.push_back('{7,  1'b0, 16'h0000, 4'hE, 4'h0, 1'b0});
    vt.push_back('{8,  1'b0, 16'h0000, 4'hF, 4'h0, 1'b0});
    vt.push_back('{10, 1'b0, 16'h0000, 4'hD, 4'h0, 1'b0});
    vt.push_back('{31, 1'b0, 16'h0000, 4'h7, 4'h0, 1'b0});
    vt.push_back('{32, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b1});
    vt.push_back('{33, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b0});
    vt.push_back('{34, 1'b0, 16'h0000, 4'hE, 4'h4, 1'b0});
    vt.push_back('{40, 1'b0, 16'h0000, 4'hF, 4'h3, 1'b0});
    vt.push_back('{42, 1'b0, 16'h0000, 4'hD, 4'h3, 1'b0});
    vt.push_back('{50, 1'b0, 16'h0000, 4'hB, 4'h2, 1'b0});
    vt.push_back('{58, 1'b0, 16'h0000, 4'h7, 4'h1, 1'b0});
    vt.push_back('{63, 1'b0, 16'h0000, 4'h7, 4'h1, 1'b0});
    vt.push_back('{64, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b1});

    @(negedge clk);
    model_reset();

    // Reset timing and deferred load, from the vector table.
    do_reset();
    k = 0;
    for (int c = 0; c < 66; c++) begin
      ld  = 1'b0;
      din = '0;
      if (k < vt.size() && vt[k].cyc == c) begin
        chk("tab_en", {28'd0, digit_en_n}, {28'd0, vt[k].en});
        chk("tab_nib", {28'd0, nibble_out}, {28'd0, vt[k].nib});
        chk("tab_tick", {31'd0, frame_tick}, {31'd0, vt[k].tick});
        ld  = vt[k].ld;
        din = vt[k].din;
        k++;
      end
      cyc(ld, din, 1'b0);
    end

    // Load in the frame_tick cycle takes effect in the same frame.
    for (int c = 0; c < F && (m_t % F) != 0; c++) cyc(1'b0, 16'h0, 1'b0);
    chk("wrap_tick", {31'd0, frame_tick}, 32'h1);
    cyc(1'b1, 16'hABCD, 1'b0);
    exp_nib_arr[0] = 4'hD;
    exp_nib_arr[1] = 4'hC;
    exp_nib_arr[2] = 4'hB;
    exp_nib_arr[3] = 4'hA;
    for (int c = 0; c < F + 2; c++) begin
      slot = (m_t % F) / DIV;
      chk("wrap_nib", {28'd0, nibble_out}, {28'd0, exp_nib_arr[slot]});
      cyc(1'b0, 16'h0, 1'b0);
    end

    // Second load before the wrap replaces the first.
    do_reset();
    seen1 = 0;
    for (int c = 0; c < 64; c++) begin
      if (nibble_out == 4'h1) seen1++;
      if (c >= 32) chk("lww_nib", {28'd0, nibble_out}, 32'h2);
      if (c == 3)       cyc(1'b1, 16'h1111, 1'b0);
      else if (c == 10) cyc(1'b1, 16'h2222, 1'b0);
      else              cyc(1'b0, 16'h0, 1'b0);
    end
    chk("lww_no_one", seen1, 0);

    // Leading-zero blanking: 0050, then all zeros.
    do_reset();
    for (int c = 0; c < 96; c++) begin
      p    = c % F;
      slot = p / DIV;
      pos  = p % DIV;
      if (c >= 32 && c != 32 && c != 64 && c != 65) begin
        if (pos < GUARD)              want_en = 4'hF;
        else if (slot == 0)           want_en = 4'hE;
        else if (c < 64 && slot == 1) want_en = 4'hD;
        else                          want_en = 4'hF;
        chk("lz_en", {28'd0, digit_en_n}, {28'd0, want_en});
        if (c < 64) chk("lz_nib", {28'd0, nibble_out}, (slot == 1) ? 32'h5 : 32'h0);
      end
      if (c == 0)       cyc(1'b1, 16'h0050, 1'b1);
      else if (c == 40) cyc(1'b1, 16'h0000, 1'b1);
      else              cyc(1'b0, 16'h0, 1'b1);
    end

    // Asynchronous reset in the middle of digit 2 drive drops a pending load.
    do_reset();
    for (int c = 0; c < 22; c++) begin
      if (c == 3) cyc(1'b1, 16'h9999, 1'b0);
      else        cyc(1'b0, 16'h0, 1'b0);
    end
    chk("mdr_before", {28'd0, digit_en_n}, 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("mdr_en", {28'd0, digit_en_n}, 32'hF);
    chk("mdr_nib", {28'd0, nibble_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 42; c++) begin
      if (c >= 32) chk("mdr_lost", {28'd0, nibble_out}, 32'h0);
      cyc(1'b0, 16'h0, 1'b0);
    end

    // Randomised traffic against the model.
    do_reset();
    blz = 1'b0;
    for (int c = 0; c < 800; c++) begin
      ld = ($urandom_range(0, 7) == 0);
      if (((m_t % F) == F - 1 || (m_t % F) == 0) && $urandom_range(0, 1) == 1) ld = 1'b1;
      for (int d = 0; d < NDIG; d++) begin
        if (d > 0 && $urandom_range(0, 1) == 0) din[d*4 +: 4] = 4'h0;
        else                                    din[d*4 +: 4] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) blz = ~blz;
      cyc(ld, din, blz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
